// File: rtl/debounce_multi.sv
// ----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel debouncer for board-level inputs such as buttons, switches and
// noisy strobes. Each channel passes through its own synchroniser and then a
// stability counter. A new level is accepted only after STABLE_CNT consecutive
// sample ticks disagree with the current debounced level. A shared prescaler
// sets the sampling rate of the filters. The synchronisers are not affected by
// the prescaler and run on every clock.
//
// Parameters
//   N_CH        number of independent channels (>= 1)
//   STABLE_CNT  consecutive differing samples needed to accept a level (>= 2)
//   CNT_W       stability counter width, must satisfy 2**CNT_W >= STABLE_CNT
//   TICK_DIV    clock cycles per sample tick (>= 1, 1 = sample every cycle)
//   SYNC_STAGES synchroniser flops per channel (>= 2)
//
// Ports
//   clk   in   rising-edge clock for all logic
//   rst   in   synchronous active-high reset
//   en    in   filter enable; when low, the counters and levels freeze
//   din   in   [N_CH] raw asynchronous inputs
//   dout  out  [N_CH] debounced levels
//   rise  out  [N_CH] one-cycle pulse in the first cycle dout[i] reads 1
//   fall  out  [N_CH] one-cycle pulse in the first cycle dout[i] reads 0
//   busy  out  high while any channel's stability counter is non-zero
// ----------------------------------------------------------------------------
module debounce_multi #(
   parameter int N_CH        = 4,
   parameter int STABLE_CNT  = 16,
   parameter int CNT_W       = 8,
   parameter int TICK_DIV    = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [N_CH-1:0] din,
   output logic [N_CH-1:0] dout,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            busy
);

   // The prescaler is at least one bit wide, so TICK_DIV=1 still has a legal
   // counter. That counter simply stays at zero.
   localparam int               P_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [P_W-1:0]   P_LAST   = P_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   // Refuse to build with parameter combinations the filter cannot honour. The
   // main case is a counter too narrow to reach STABLE_CNT-1.
   generate
      if (CNT_W < 1 || (CNT_W < 31 && (2 ** CNT_W) < STABLE_CNT)) begin : g_bad_cnt_w
         $error("debounce_multi: CNT_W too small for STABLE_CNT");
      end
      if (N_CH < 1 || STABLE_CNT < 2 || TICK_DIV < 1 || SYNC_STAGES < 2) begin : g_bad_param
         $error("debounce_multi: parameter out of range");
      end
   endgenerate

   logic [N_CH-1:0][SYNC_STAGES-1:0] sync;
   logic [N_CH-1:0]                  s;
   logic [P_W-1:0]                   p;
   logic                             tick;
   logic [N_CH-1:0][CNT_W-1:0]       cnt;
   logic [N_CH-1:0][CNT_W-1:0]       cnt_n;
   logic [N_CH-1:0]                  dout_n;
   logic [N_CH-1:0]                  rise_n;
   logic [N_CH-1:0]                  fall_n;
   logic                             active_n;

   // Synchroniser shift chains. The chains shift on every clock, whatever the
   // enable or prescaler state, so the filter always sees a fresh and
   // metastability-settled copy of each input. Bit 0 takes the raw input, and
   // the top bit is the synchronised value.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            sync[i] <= {sync[i][SYNC_STAGES-2:0], din[i]};
         end
      end
   end

   // Pick out the last synchroniser stage of each channel as its sample.
   always_comb begin
      s = '0;
      for (int i = 0; i < N_CH; i++) begin
         s[i] = sync[i][SYNC_STAGES-1];
      end
   end

   // Shared prescaler. Clearing it while disabled means that, after
   // re-enable, the first sample tick comes a full TICK_DIV cycles later. It
   // never arrives early from a stale phase.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         p <= '0;
      end else if (p == P_LAST) begin
         p <= '0;
      end else begin
         p <= p + 1'b1;
      end
   end

   assign tick = en && (p == P_LAST);

   // Next-state logic for the per-channel filters. Without a tick everything
   // holds. A sample that agrees with the current level restarts the count,
   // which is what rejects glitches. The count saturates at STABLE_CNT-1; the
   // next disagreeing sample after that accepts the new level and raises the
   // matching edge pulse in the same step. The edge pulse therefore lines up
   // with the first cycle of the new level.
   always_comb begin
      cnt_n    = cnt;
      dout_n   = dout;
      rise_n   = '0;
      fall_n   = '0;
      active_n = 1'b0;
      if (tick) begin
         for (int i = 0; i < N_CH; i++) begin
            if (s[i] == dout[i]) begin
               cnt_n[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
               cnt_n[i]  = '0;
               dout_n[i] = s[i];
               rise_n[i] = s[i];
               fall_n[i] = !s[i];
            end else begin
               cnt_n[i] = cnt[i] + 1'b1;
            end
         end
      end
      for (int i = 0; i < N_CH; i++) begin
         if (cnt_n[i] != '0) begin
            active_n = 1'b1;
         end
      end
   end

   // Filter state and registered outputs. busy is taken from the next-state
   // counters, so it is high in exactly the cycles where some counter reads
   // non-zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         dout <= '0;
         rise <= '0;
         fall <= '0;
         busy <= 1'b0;
      end else begin
         cnt  <= cnt_n;
         dout <= dout_n;
         rise <= rise_n;
         fall <= fall_n;
         busy <= active_n;
      end
   end

endmodule
